// File: rtl/m68k_slave_regs.sv
// 68000 bus target: three read/write registers plus a read-only status word in a 64 KB window,
// paced by a programmable wait-state counter and a DTACK handshake.
module m68k_slave_regs #(
    parameter logic [7:0] BASE_ADDR   = 8'hE9,
    parameter int         WAIT_STATES = 2
) (
    input  logic        M68K_CLK,
    input  logic        _rst_in,
    input  logic [23:1] M68K_A,
    input  logic [15:0] M68K_D_IN,
    output logic [15:0] M68K_D_OUT,
    output logic        M68K_D_OE,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    output logic        DTACK_PULL,
    input  logic [15:0] STATUS_IN,
    output logic [47:0] CTRL_OUT,
    output logic        WR_PULSE,
    output logic [1:0]  WR_IDX,
    output logic [1:0]  fsm_state
);

    // Bus handshake: a cycle is taken only from IDLE when AS_n is low and the
    // address hits; DTACK_PULL stays high until AS_n is sampled high again.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       cnt;
    logic [1:0]       idx_q;
    logic             rw_q;
    logic [2:0][15:0] regs;
    logic [15:0]      d_out_q;
    logic             dtack_q;
    logic             wr_pulse_q;
    logic [1:0]       wr_idx_q;

    logic             hit;
    logic             start;
    logic             enter_ack;
    logic [1:0]       sel_idx;
    logic [15:0]      sel_data;

    assign hit       = (M68K_A[23:16] == BASE_ADDR);
    assign start     = (state == S_IDLE) && !M68K_AS_n && hit;
    assign enter_ack = (state == S_WAIT) && !M68K_AS_n && (cnt == 3'd0) &&
                       (rw_q || !M68K_UDS_n || !M68K_LDS_n);

    // In IDLE the read mux follows the live address so D_OUT is valid right after decode.
    assign sel_idx = (state == S_IDLE) ? M68K_A[2:1] : idx_q;

    always_comb begin
        sel_data = STATUS_IN;
        case (sel_idx)
            2'd0:    sel_data = regs[0];
            2'd1:    sel_data = regs[1];
            2'd2:    sel_data = regs[2];
            default: sel_data = STATUS_IN;
        endcase
    end

    always_ff @(posedge M68K_CLK or posedge _rst_in) begin
        if (_rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_WAIT;
            S_WAIT: begin
                if (M68K_AS_n) begin
                    state_nxt = S_IDLE;
                end else if (enter_ack) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK:   if (M68K_AS_n) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        DTACK_PULL = dtack_q;
        M68K_D_OE  = (state != S_IDLE) && rw_q && !M68K_AS_n;
        M68K_D_OUT = d_out_q;
        WR_PULSE   = wr_pulse_q;
        WR_IDX     = wr_idx_q;
        CTRL_OUT   = {regs[2], regs[1], regs[0]};
        fsm_state  = state;
    end

    always_ff @(posedge M68K_CLK or posedge _rst_in) begin
        if (_rst_in) begin
            cnt        <= 3'd0;
            idx_q      <= 2'd0;
            rw_q       <= 1'b0;
            regs       <= '0;
            d_out_q    <= 16'h0000;
            dtack_q    <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= 2'd0;
        end else begin
            wr_pulse_q <= 1'b0;
            dtack_q    <= (state_nxt == S_ACK);

            if (start) begin
                idx_q <= M68K_A[2:1];
                rw_q  <= M68K_RW;
                cnt   <= WS_LOAD;
            end else if ((state == S_WAIT) && !M68K_AS_n && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end

            // Refreshed every active clock so status reads stay current until DTACK.
            if (start || (state != S_IDLE)) begin
                d_out_q <= sel_data;
            end

            // Writes to the status slot are acknowledged but dropped.
            if (enter_ack && !rw_q && (idx_q != 2'd3)) begin
                for (int i = 0; i < 3; i++) begin
                    if (idx_q == 2'(i)) begin
                        if (!M68K_UDS_n) regs[i][15:8] <= M68K_D_IN[15:8];
                        if (!M68K_LDS_n) regs[i][7:0]  <= M68K_D_IN[7:0];
                    end
                end
                wr_pulse_q <= 1'b1;
                wr_idx_q   <= idx_q;
            end
        end
    end

endmodule

// File: tb/tb_m68k_slave_regs.sv
// Bench for m68k_slave_regs: two targets (0xE9 with two wait states, 0xE7 with none)
// share one bus; a bus-level model predicts every output and is compared each clock.
module tb_m68k_slave_regs;

    logic        clk;
    logic        rst;
    logic [23:1] a;
    logic [15:0] d_in;
    logic        as_n, uds_n, lds_n, rw;
    logic [15:0] status_in;

    logic [15:0] d_out [2];
    logic        d_oe  [2];
    logic        dtack [2];
    logic [47:0] ctrl  [2];
    logic        pulse [2];
    logic [1:0]  widx  [2];
    logic [1:0]  fsm   [2];

    logic [15:0] m_regs    [2][3];
    logic        exp_dtack [2];
    logic        exp_oe    [2];
    logic        exp_pulse [2];
    logic [1:0]  exp_idx   [2];
    logic [15:0] exp_dout  [2];
    logic        dout_chk  [2];
    logic        chk_en;

    int n_checks;
    int n_errors;

    m68k_slave_regs #(.BASE_ADDR(8'hE9), .WAIT_STATES(2)) dut_a (
        .M68K_CLK(clk), ._rst_in(rst), .M68K_A(a), .M68K_D_IN(d_in),
        .M68K_D_OUT(d_out[0]), .M68K_D_OE(d_oe[0]), .M68K_AS_n(as_n),
        .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
        .DTACK_PULL(dtack[0]), .STATUS_IN(status_in), .CTRL_OUT(ctrl[0]),
        .WR_PULSE(pulse[0]), .WR_IDX(widx[0]), .fsm_state(fsm[0])
    );

    m68k_slave_regs #(.BASE_ADDR(8'hE7), .WAIT_STATES(0)) dut_b (
        .M68K_CLK(clk), ._rst_in(rst), .M68K_A(a), .M68K_D_IN(d_in),
        .M68K_D_OUT(d_out[1]), .M68K_D_OE(d_oe[1]), .M68K_AS_n(as_n),
        .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
        .DTACK_PULL(dtack[1]), .STATUS_IN(status_in), .CTRL_OUT(ctrl[1]),
        .WR_PULSE(pulse[1]), .WR_IDX(widx[1]), .fsm_state(fsm[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int i, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, i, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("dtack", i, 48'(dtack[i]), 48'(exp_dtack[i]));
                chk("d_oe", i, 48'(d_oe[i]), 48'(exp_oe[i]));
                chk("wr_pulse", i, 48'(pulse[i]), 48'(exp_pulse[i]));
                chk("wr_idx", i, 48'(widx[i]), 48'(exp_idx[i]));
                chk("ctrl_out", i, ctrl[i], {m_regs[i][2], m_regs[i][1], m_regs[i][0]});
                if (dout_chk[i]) chk("d_out", i, 48'(d_out[i]), 48'(exp_dout[i]));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 3; r++) m_regs[i][r] = 16'h0000;
            exp_dtack[i] = 1'b0;
            exp_oe[i]    = 1'b0;
            exp_pulse[i] = 1'b0;
            exp_idx[i]   = 2'd0;
            exp_dout[i]  = 16'h0000;
            dout_chk[i]  = 1'b1;
        end
    endtask

    function automatic logic [15:0] model_read(input int t, input logic [1:0] idx);
        return (idx == 2'd3) ? status_in : m_regs[t][idx];
    endfunction

    // One complete bus cycle. Called at posedge+1. DS asserted before edge N+ds_delay;
    // abort_at >= 1 raises AS before edge N+abort_at; status_new applied after edge N+status_at.
    task automatic bus_cycle(input logic [23:0] addr, input bit rd, input logic [15:0] wdata,
                             input bit use_uds, input bit use_lds, input int ds_delay,
                             input int abort_at, input logic [15:0] status_new,
                             input int status_at, input bit rst_in_ack,
                             output int ack_seen, output logic [15:0] dout_ack);
        int         t;
        int         e_rel;
        bit         aborted;
        logic [1:0] idx;
        t        = (addr[23:16] == 8'hE9) ? 0 : (addr[23:16] == 8'hE7) ? 1 : -1;
        idx      = addr[2:1];
        e_rel    = (t == 0) ? 3 : (t == 1) ? 1 : 4;
        if (!rd && (ds_delay > e_rel)) e_rel = ds_delay;
        ack_seen = -1;
        dout_ack = 16'h0000;
        aborted  = 1'b0;
        a    = addr[23:1];
        rw   = rd;
        d_in = wdata;
        as_n = 1'b0;
        for (int k = 0; k <= e_rel; k++) begin
            if (k == abort_at) begin
                as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
                if (t >= 0) begin exp_oe[t] = 1'b0; dout_chk[t] = 1'b0; end
                aborted = 1'b1;
            end else if (rd || k >= ds_delay) begin
                uds_n = rd ? 1'b0 : !use_uds;
                lds_n = rd ? 1'b0 : !use_lds;
            end
            @(posedge clk); #1;
            if (t >= 0 && dtack[t] && ack_seen < 0) begin
                ack_seen = k;
                dout_ack = d_out[t];
            end
            if (aborted) break;
            if (t >= 0) begin
                exp_oe[t]    = rd;
                exp_pulse[t] = 1'b0;
                dout_chk[t]  = rd;
                if (rd) exp_dout[t] = model_read(t, idx);
                if (k == e_rel) begin
                    exp_dtack[t] = 1'b1;
                    if (!rd && idx != 2'd3) begin
                        if (use_uds) m_regs[t][idx][15:8] = wdata[15:8];
                        if (use_lds) m_regs[t][idx][7:0]  = wdata[7:0];
                        exp_pulse[t] = 1'b1;
                        exp_idx[t]   = idx;
                    end
                end
            end
            if (k == status_at) status_in = status_new;
        end
        if (aborted || t < 0) begin
            as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        end else if (rst_in_ack) begin
            rst = 1'b1;
            model_reset();
            #1;
            chk("async_dtack_drop", t, 48'(dtack[t]), 48'(1'b0));
            chk("async_oe_drop", t, 48'(d_oe[t]), 48'(1'b0));
            @(posedge clk); #1;
            rst = 1'b0;
            as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        end else begin
            @(posedge clk); #1;
            exp_pulse[t] = 1'b0;
            if (rd) exp_dout[t] = model_read(t, idx);
            as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
            exp_oe[t]   = 1'b0;
            dout_chk[t] = 1'b0;
            @(posedge clk); #1;
            exp_dtack[t] = 1'b0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) dout_chk[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ack;
        logic [15:0] dv;
        n_checks  = 0;
        n_errors  = 0;
        chk_en    = 1'b0;
        rst       = 1'b1;
        a         = '0;
        d_in      = 16'h0000;
        as_n      = 1'b1;
        uds_n     = 1'b1;
        lds_n     = 1'b1;
        rw        = 1'b1;
        status_in = 16'h0000;
        model_reset();
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) dout_chk[i] = 1'b0;
        @(posedge clk); #1;

        // Word write 0x1234 to reg 1 with two wait states.
        bus_cycle(24'hE90002, 0, 16'h1234, 1, 1, 0, -1, 16'h0, -1, 0, ack, dv);
        chk("latency_ws2", 0, 48'(ack), 48'(3));
        chk("reg1_word", 0, 48'(ctrl[0][31:16]), 48'(16'h1234));

        // Byte-lane writes into reg 0.
        bus_cycle(24'hE90000, 0, 16'hAB77, 1, 0, 0, -1, 16'h0, -1, 0, ack, dv);
        chk("reg0_upper", 0, 48'(ctrl[0][15:0]), 48'(16'hAB00));
        bus_cycle(24'hE9FFF8, 0, 16'h11CD, 0, 1, 0, -1, 16'h0, -1, 0, ack, dv);
        chk("reg0_lower", 0, 48'(ctrl[0][15:0]), 48'(16'hABCD));

        // Status read with STATUS_IN changing during WAIT.
        status_in = 16'h5A5A;
        bus_cycle(24'hE90006, 1, 16'h0, 1, 1, 0, -1, 16'hA5A5, 1, 0, ack, dv);
        chk("status_fresh", 0, 48'(dv), 48'(16'hA5A5));
        chk("latency_read", 0, 48'(ack), 48'(3));

        bus_cycle(24'hE90012, 1, 16'h0, 0, 1, 0, -1, 16'h0, -1, 0, ack, dv);
        chk("reg1_read", 0, 48'(dv), 48'(16'h1234));

        // Miss, then a discarded write to reg 3.
        bus_cycle(24'hE80000, 0, 16'hFFFF, 1, 1, 0, -1, 16'h0, -1, 0, ack, dv);
        chk("miss_no_dtack", 0, 48'(ack), 48'(-1));
        bus_cycle(24'hE90006, 0, 16'hFFFF, 1, 1, 0, -1, 16'h0, -1, 0, ack, dv);
        chk("reg3_wr_ack", 0, 48'(ack), 48'(3));
        chk("reg3_wr_drop", 0, ctrl[0], 48'h0000_1234_ABCD);

        // AS negated during WAIT.
        bus_cycle(24'hE90004, 0, 16'h5555, 1, 1, 0, 2, 16'h0, -1, 0, ack, dv);
        chk("abort_no_dtack", 0, 48'(ack), 48'(-1));
        chk("abort_no_write", 0, 48'(ctrl[0][47:32]), 48'(16'h0000));

        // Zero wait states, data strobe two clocks late.
        bus_cycle(24'hE70004, 0, 16'hBEEF, 1, 1, 2, -1, 16'h0, -1, 0, ack, dv);
        chk("latency_late_ds", 1, 48'(ack), 48'(2));
        chk("reg2_ws0", 1, 48'(ctrl[1][47:32]), 48'(16'hBEEF));
        bus_cycle(24'hE70002, 1, 16'h0, 1, 1, 0, -1, 16'h0, -1, 0, ack, dv);
        chk("latency_ws0_read", 1, 48'(ack), 48'(1));

        // Reset pulsed while acknowledging a read.
        bus_cycle(24'hE90000, 1, 16'h0, 1, 1, 0, -1, 16'h0, -1, 1, ack, dv);
        chk("rst_read_data", 0, 48'(dv), 48'(16'hABCD));
        chk("rst_ctrl_clear", 0, ctrl[0], 48'h0);

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/m68k_slave_regs.md
# m68k_slave_regs

Responder-side 68000 bus target for the Pistorm'X CPLD: decodes host 68k bus cycles (from the original 68000 or from the Pistorm acting as bus master) that hit a 64 KB window and serves a small register file. It paces each access with a programmable wait-state counter and a DTACK handshake. Byte-lane writes are honoured. Completed writes are signalled to the rest of the CPLD, for example the ON/OFF or RAM-mode control logic. The top level owns the tri-state pads. This block only produces drive values and enables.

## Interface
Parameters:
- BASE_ADDR, 8'hE9: match value for M68K_A[23:16].
- WAIT_STATES, 2: clocks inserted between decode and DTACK. Legal range is 0..7, held in a 3-bit counter.

Ports:
- M68K_CLK  in  1  68k bus clock, 7 MHz; all state updates on its rising edge.
- _rst_in  in  1  reset, asynchronous, active-high.
- M68K_A  in  23  address bus [23:1].
- M68K_D_IN  in  16  data bus as sampled from pads.
- M68K_D_OUT  out  16  read data to drive.
- M68K_D_OE  out  1  1 = top drives M68K_D_OUT onto bus.
- M68K_AS_n, M68K_UDS_n, M68K_LDS_n  in  1 each  strobes, active-low.
- M68K_RW  in  1  1 = read, 0 = write.
- DTACK_PULL  out  1  1 = top pulls M68K_DTACK_n low, else Z.
- STATUS_IN  in  16  contents returned for reg 3, read-only.
- CTRL_OUT  out  48  {reg2, reg1, reg0}.
- WR_PULSE  out  1  one-clock pulse per completed write to reg 0..2.
- WR_IDX  out  2  index of last written reg, valid with WR_PULSE.

## Operation
- Register select: `idx = M68K_A[2:1]`. A hit requires `M68K_A[23:16] == BASE_ADDR`. A[15:3] are don't-care, so the 4 registers alias across the 64 KB window.
- Regs 0..2 are read/write storage with a reset value of 16'h0000. Reg 3 reads STATUS_IN. Writes to reg 3 are acknowledged and then discarded, with no WR_PULSE.
- State machine with 3 states: IDLE, WAIT, ACK.
  - IDLE: on a rising edge with `!AS_n & hit`:
    - latch `idx` and `rw`;
    - load `cnt = WAIT_STATES`;
    - go to WAIT.
  - WAIT:
    - If `AS_n` is high, the cycle was aborted: go to IDLE with no side effects.
    - Else if `cnt != 0`, decrement `cnt`.
    - Else if `cnt == 0` and (`rw` = 1, or `UDS_n` low, or `LDS_n` low), go to ACK. On a write, stay in WAIT until a data strobe is asserted.
  - ACK, on the entry edge for a write:
    - `reg[idx][15:8] <= D_IN[15:8]` if `!UDS_n`;
    - `reg[idx][7:0] <= D_IN[7:0]` if `!LDS_n`;
    - WR_PULSE = 1 for that one clock if `idx != 3`.
    - Hold ACK until `AS_n` is sampled high, then go to IDLE.
- DTACK_PULL is registered and equals (state == ACK).
- M68K_D_OUT is the selected register, or STATUS_IN for reg 3. It is registered at IDLE→WAIT and refreshed every clock while in WAIT or ACK, so reg 3 reads are current.
- `M68K_D_OE = (state != IDLE) & rw & !M68K_AS_n`. This is combinational so the bus is released as soon as AS negates.
- Byte reads return the full word. The master selects the lane.
- Misses and non-hit cycles: no DTACK, no drive, state stays IDLE.

## Timing
- Reset while `_rst_in` is high:
  - state = IDLE, `cnt = 0`;
  - DTACK_PULL = 0, M68K_D_OE = 0, M68K_D_OUT = 0;
  - CTRL_OUT = 0, WR_PULSE = 0, WR_IDX = 0.
- Reset asserted mid-cycle aborts immediately: DTACK and data drive release asynchronously, and no register write occurs.
- Latency: AS low plus hit sampled at edge N. For reads, and for writes whose DS is already low, DTACK_PULL rises at edge `N+1+WAIT_STATES`. With WAIT_STATES = 0, that is edge N+1.
- Release: AS_n sampled high at edge M gives DTACK_PULL = 0 after edge M. D_OE drops combinationally, before M.
- Back-to-back: a new AS falling edge is accepted only from IDLE. A minimum of one IDLE clock separates cycles.
- WR_PULSE occurs at the ACK-entry clock. CTRL_OUT updates on the same edge.

## Test plan
- Word write to 0xE90002, data 0x1234, WAIT_STATES = 2: DTACK_PULL at N+3, CTRL_OUT[31:16] = 0x1234, one WR_PULSE with WR_IDX = 1, DTACK released the clock after AS high.
- Byte writes to reg 0:
  - UDS-only write with 0xAB__ on a reg 0 holding 0x0000 gives reg0 = 0xAB00;
  - then an LDS-only write with __CD gives 0xABCD.
- Read reg 3 with STATUS_IN = 0x5A5A, then change it to 0xA5A5 during WAIT: bus shows 0xA5A5 at DTACK, D_OE = 1 only while AS is low, no WR_PULSE.
- Address 0xE80000, a miss: no DTACK, no D_OE, regs unchanged. Write to reg 3: DTACK is given, no WR_PULSE, CTRL_OUT unchanged.
- Abort and reset:
  - AS negated during WAIT: IDLE, no DTACK, no write;
  - `_rst_in` pulsed in ACK: DTACK and D_OE drop at once, CTRL_OUT = 0.
- WAIT_STATES = 0 with a write whose DS arrives 2 clocks after AS: stays in WAIT, and ACK follows the first edge with DS low.
